// File: rtl/key_event_if.sv
// Key event bus: debounced key level in, event strobes, held level and press count out.
// The key_event block connects through the slave modport; its driver uses master.
interface key_event_if;
    logic       key_db;
    logic       press_p;
    logic       release_p;
    logic       long_p;
    logic       repeat_p;
    logic       held;
    logic [7:0] press_cnt;

    modport master (
        output key_db,
        input  press_p,
        input  release_p,
        input  long_p,
        input  repeat_p,
        input  held,
        input  press_cnt
    );

    modport slave (
        input  key_db,
        output press_p,
        output release_p,
        output long_p,
        output repeat_p,
        output held,
        output press_cnt
    );
endinterface

// File: rtl/key_event.sv
// Turns a debounced key level into press/release/long/auto-repeat strobes, a held level and a press count.
// Optional auto-repeat is compiled in when KEY_EVENT_REPEAT_EN is defined.
module key_event #(
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned LONG_CYCLES   = 20_000_000,
    parameter int unsigned REPEAT_CYCLES = 4_000_000,
    parameter int unsigned CNT_W         = 25
) (
    input  logic        clk,
    input  logic        n_rst,
    key_event_if.slave  ev
);

    typedef enum logic [1:0] {
        ST_ARM,
        ST_IDLE,
        ST_HELD,
        ST_LONG
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             held_q, held_d;
    logic [7:0]       press_cnt_q, press_cnt_d;
    logic             lvl;

`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic repeat_q, repeat_d;
`else
    logic unused_repeat_cycles;
    assign unused_repeat_cycles = (REPEAT_CYCLES == 0);
`endif

    // Normalised level: 1 means the key is pressed regardless of board polarity.
    assign lvl = ev.key_db ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_ARM;
            cnt_q       <= '0;
            prev_q      <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            held_q      <= 1'b0;
            press_cnt_q <= 8'd0;
`ifdef KEY_EVENT_REPEAT_EN
            repeat_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_q      <= lvl;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            held_q      <= held_d;
            press_cnt_q <= press_cnt_d;
`ifdef KEY_EVENT_REPEAT_EN
            repeat_q    <= repeat_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        held_d      = 1'b0;
        press_cnt_d = press_cnt_q;
`ifdef KEY_EVENT_REPEAT_EN
        repeat_d    = 1'b0;
`endif
        unique case (state_q)
            // Wait for a released sample so a key held through reset is not reported.
            ST_ARM: begin
                if (!lvl) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (lvl && !prev_q) begin
                    press_d     = 1'b1;
                    held_d      = 1'b1;
                    cnt_d       = '0;
                    press_cnt_d = press_cnt_q + 8'd1;
                    state_d     = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!lvl) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    held_d = 1'b1;
                    if (cnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_LONG;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_LONG: begin
                if (!lvl) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    held_d = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
                    if (cnt_q == REPEAT_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    assign ev.press_p   = press_q;
    assign ev.release_p = release_q;
    assign ev.long_p    = long_q;
    assign ev.held      = held_q;
    assign ev.press_cnt = press_cnt_q;
`ifdef KEY_EVENT_REPEAT_EN
    assign ev.repeat_p  = repeat_q;
`else
    assign ev.repeat_p  = 1'b0;
`endif

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: arming, short/long presses, auto-repeat, counter wrap, polarity and reset abort.
// Expected repeat strobes follow whether KEY_EVENT_REPEAT_EN is defined for the build.
module tb_key_event;

`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    // Output vector layout: {held, press_p, release_p, long_p, repeat_p}
    localparam logic [4:0] V_NONE  = 5'b00000;
    localparam logic [4:0] V_PRESS = 5'b11000;
    localparam logic [4:0] V_HOLD  = 5'b10000;
    localparam logic [4:0] V_REL   = 5'b00100;
    localparam logic [4:0] V_LONG  = 5'b10010;
    localparam logic [4:0] V_REP   = 5'b10001;

    logic clk = 1'b0;
    logic n_rst;
    logic n_rst_al;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    key_event_if ev();
    key_event_if ev_al();

    key_event #(
        .ACTIVE_LOW   (1'b0),
        .LONG_CYCLES  (10),
        .REPEAT_CYCLES(4),
        .CNT_W        (8)
    ) u_dut (
        .clk  (clk),
        .n_rst(n_rst),
        .ev   (ev.slave)
    );

    key_event #(
        .ACTIVE_LOW   (1'b1),
        .LONG_CYCLES  (10),
        .REPEAT_CYCLES(4),
        .CNT_W        (8)
    ) u_dut_al (
        .clk  (clk),
        .n_rst(n_rst_al),
        .ev   (ev_al.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {ev.held, ev.press_p, ev.release_p, ev.long_p, ev.repeat_p};
    endfunction

    function automatic logic [4:0] outs_al();
        return {ev_al.held, ev_al.press_p, ev_al.release_p, ev_al.long_p, ev_al.repeat_p};
    endfunction

    task automatic cyc(input logic k);
        ev.key_db = k;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_al(input logic k);
        ev_al.key_db = k;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp_v;

        n_rst        = 1'b0;
        n_rst_al     = 1'b0;
        ev.key_db    = 1'b1;
        ev_al.key_db = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs()), 32'(V_NONE));
        check("reset_cnt", 32'(ev.press_cnt), 32'd0);

        // Key pressed through reset: no strobe until a release has been seen.
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1);
            check("arm_quiet", 32'(outs()), 32'(V_NONE));
        end
        cyc(1'b0);
        check("arm_release", 32'(outs()), 32'(V_NONE));
        cyc(1'b1);
        check("first_press", 32'(outs()), 32'(V_PRESS));
        check("first_cnt", 32'(ev.press_cnt), 32'd1);
        cyc(1'b0);
        check("first_release", 32'(outs()), 32'(V_REL));
        $display("txn arm: checks=%0d errors=%0d", checks, errors);

        // Short press: held for 5 cycles, no long strobe.
        cyc(1'b1);
        check("short_press", 32'(outs()), 32'(V_PRESS));
        for (int i = 1; i < 5; i++) begin
            cyc(1'b1);
            check("short_hold", 32'(outs()), 32'(V_HOLD));
        end
        cyc(1'b0);
        check("short_release", 32'(outs()), 32'(V_REL));
        cyc(1'b0);
        check("short_idle", 32'(outs()), 32'(V_NONE));
        check("short_cnt", 32'(ev.press_cnt), 32'd2);
        $display("txn short: checks=%0d errors=%0d", checks, errors);

        // Long press: long at P+10, repeats at P+14, P+18, P+22.
        for (int i = 0; i < 25; i++) begin
            cyc(1'b1);
            if (i == 0)
                exp_v = V_PRESS;
            else if (i == 10)
                exp_v = V_LONG;
            else if (REP_ON && (i == 14 || i == 18 || i == 22))
                exp_v = V_REP;
            else
                exp_v = V_HOLD;
            check($sformatf("long_c%0d", i), 32'(outs()), 32'(exp_v));
        end
        cyc(1'b0);
        check("long_release", 32'(outs()), 32'(V_REL));
        check("long_cnt", 32'(ev.press_cnt), 32'd3);
        $display("txn long: repeat_en=%0d checks=%0d errors=%0d", REP_ON, checks, errors);

        // Release sampled on the edge that would have produced long_p.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1);
            check($sformatf("edge_c%0d", i), 32'(outs()), 32'(i == 0 ? V_PRESS : V_HOLD));
        end
        cyc(1'b0);
        check("edge_release_only", 32'(outs()), 32'(V_REL));
        cyc(1'b0);
        check("edge_no_late_long", 32'(outs()), 32'(V_NONE));
        check("edge_cnt", 32'(ev.press_cnt), 32'd4);
        $display("txn long_boundary: checks=%0d errors=%0d", checks, errors);

        // Counter wrap with back-to-back press/release samples.
        n_rst = 1'b0;
        #1;
        check("wrap_reset_outs", 32'(outs()), 32'(V_NONE));
        check("wrap_reset_cnt", 32'(ev.press_cnt), 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        cyc(1'b0);
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1);
            check("wrap_press", 32'(outs()), 32'(V_PRESS));
            check("wrap_cnt", 32'(ev.press_cnt), 32'((i + 1) % 256));
            cyc(1'b0);
            check("wrap_release", 32'(outs()), 32'(V_REL));
        end
        check("wrap_zero", 32'(ev.press_cnt), 32'd0);
        cyc(1'b1);
        check("wrap_257_press", 32'(outs()), 32'(V_PRESS));
        check("wrap_257_cnt", 32'(ev.press_cnt), 32'd1);
        cyc(1'b0);
        $display("txn wrap: checks=%0d errors=%0d", checks, errors);

        // Active-low key: key_db=0 means pressed.
        n_rst_al = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc_al(1'b0);
            check("al_arm_quiet", 32'(outs_al()), 32'(V_NONE));
        end
        cyc_al(1'b1);
        check("al_arm_release", 32'(outs_al()), 32'(V_NONE));
        cyc_al(1'b0);
        check("al_press", 32'(outs_al()), 32'(V_PRESS));
        check("al_cnt", 32'(ev_al.press_cnt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc_al(1'b0);
            check("al_hold", 32'(outs_al()), 32'(V_HOLD));
        end
        // Reset mid-cycle while held: outputs clear without a clock edge.
        #2;
        n_rst_al = 1'b0;
        #1;
        check("al_abort_outs", 32'(outs_al()), 32'(V_NONE));
        check("al_abort_cnt", 32'(ev_al.press_cnt), 32'd0);
        @(posedge clk);
        #1;
        check("al_abort_no_release", 32'(outs_al()), 32'(V_NONE));
        n_rst_al = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc_al(1'b0);
            check("al_rearm_quiet", 32'(outs_al()), 32'(V_NONE));
        end
        cyc_al(1'b1);
        check("al_rearm_no_release", 32'(outs_al()), 32'(V_NONE));
        cyc_al(1'b0);
        check("al_repress", 32'(outs_al()), 32'(V_PRESS));
        check("al_repress_cnt", 32'(ev_al.press_cnt), 32'd1);
        $display("txn active_low: checks=%0d errors=%0d", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
